// File: rtl/agex_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : agex_hazard_ctrl_pkg
// Purpose : Shared constants for the DE/AGEX hazard controller: register
//           index width, scoreboard saturation value and FSM encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package agex_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DEF_CNT_W = 2;

  // Largest count representable by a scoreboard counter of width w.
  function automatic int cnt_max_f(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cnt_max_f(DEF_CNT_W);

  // Branch sequencing FSM encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BR_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/agex_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : agex_hazard_ctrl_if
// Purpose : Bundles the DE, AGEX and WB status signals seen by the hazard
//           controller and the stall/issue/flush controls it returns.
// Ports   : master - pipeline side (drives DE/AGEX/WB status, reads controls)
//           slave  - controller side
// Revision: 1.0 - initial release
// ============================================================================
interface agex_hazard_ctrl_if;
  import agex_hazard_ctrl_pkg::*;

  logic                 de_valid;
  logic [REG_IDX_W-1:0] de_rs1;
  logic [REG_IDX_W-1:0] de_rs2;
  logic                 de_use_rs1;
  logic                 de_use_rs2;
  logic [REG_IDX_W-1:0] de_rd;
  logic                 de_wr_reg;
  logic                 de_is_branch;
  logic                 agex_br_resolve;
  logic                 agex_br_taken;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 wb_wr_reg;
  logic                 stall_de;
  logic                 issue;
  logic                 flush_fe;
  logic                 busy_br;

  modport master (
    output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd, de_wr_reg,
           de_is_branch, agex_br_resolve, agex_br_taken, wb_valid, wb_rd,
           wb_wr_reg,
    input  stall_de, issue, flush_fe, busy_br
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd, de_wr_reg,
           de_is_branch, agex_br_resolve, agex_br_taken, wb_valid, wb_rd,
           wb_wr_reg,
    output stall_de, issue, flush_fe, busy_br
  );

endinterface
`default_nettype wire

// File: rtl/agex_hazard_ctrl_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : Per-register count of in-flight writes with lookups for the two
//           source ports and the destination port.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           inc_i/inc_rd_i    - an issued writer of inc_rd_i
//           dec_i/dec_rd_i    - a retiring writer of dec_rd_i
//           rs1_i/rs2_i/rd_i  - lookup indices
//           busy_rs1_o/busy_rs2_o - source has an outstanding write
//           full_rd_o         - destination counter saturated
// Config  : AGEX_HAZARD_WB_BYPASS_EN - a source whose only outstanding write
//           retires this cycle is not reported busy.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import agex_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 inc_i,
  input  wire logic [REG_IDX_W-1:0] inc_rd_i,
  input  wire logic                 dec_i,
  input  wire logic [REG_IDX_W-1:0] dec_rd_i,
  input  wire logic [REG_IDX_W-1:0] rs1_i,
  input  wire logic [REG_IDX_W-1:0] rs2_i,
  input  wire logic [REG_IDX_W-1:0] rd_i,
  output logic                      busy_rs1_o,
  output logic                      busy_rs2_o,
  output logic                      full_rd_o
);

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(cnt_max_f(CNT_W));

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  // x0 is never tracked; its counter stays at zero.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i != 0) begin
        if (inc_i && inc_rd_i == REG_IDX_W'(i) &&
            !(dec_i && dec_rd_i == REG_IDX_W'(i))) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (dec_i && dec_rd_i == REG_IDX_W'(i) &&
                     !(inc_i && inc_rd_i == REG_IDX_W'(i)) &&
                     cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef AGEX_HAZARD_WB_BYPASS_EN
  // The register file writes before it reads, so the last outstanding write
  // retiring this cycle is already visible to the reader.
  assign busy_rs1_o = (cnt_q[rs1_i] != '0) &&
                      !(cnt_q[rs1_i] == CNT_W'(1) && dec_i && dec_rd_i == rs1_i);
  assign busy_rs2_o = (cnt_q[rs2_i] != '0) &&
                      !(cnt_q[rs2_i] == CNT_W'(1) && dec_i && dec_rd_i == rs2_i);
`else
  assign busy_rs1_o = (cnt_q[rs1_i] != '0);
  assign busy_rs2_o = (cnt_q[rs2_i] != '0);
`endif

  assign full_rd_o = (cnt_q[rd_i] == C_CNT_FULL);

endmodule
`default_nettype wire

// File: rtl/agex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : agex_hazard_ctrl
// Purpose : DE->AGEX issue control. Stalls DE on RAW hazards, on a saturated
//           destination counter and while a branch/jump is outstanding; holds
//           flush_fe for FLUSH_CYCLES cycles after a taken redirect.
// Ports   : clk, reset - clock, synchronous active-high reset
//           bus        - agex_hazard_ctrl_if.slave (DE/AGEX/WB status in,
//                        stall_de/issue/flush_fe/busy_br out)
// Config  : AGEX_HAZARD_WB_BYPASS_EN - allow issue in the same cycle WB
//           retires the last outstanding write of a source register.
// Revision: 1.0 - initial release
// ============================================================================
module agex_hazard_ctrl
  import agex_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  agex_hazard_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [1:0]      state_q, state_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;

  logic busy_rs1, busy_rs2, full_rd;
  logic raw_hazard, waw_full, stall, iss, inc_en, dec_en;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (inc_en),
    .inc_rd_i   (bus.de_rd),
    .dec_i      (dec_en),
    .dec_rd_i   (bus.wb_rd),
    .rs1_i      (bus.de_rs1),
    .rs2_i      (bus.de_rs2),
    .rd_i       (bus.de_rd),
    .busy_rs1_o (busy_rs1),
    .busy_rs2_o (busy_rs2),
    .full_rd_o  (full_rd)
  );

  assign raw_hazard = (bus.de_use_rs1 && bus.de_rs1 != '0 && busy_rs1) ||
                      (bus.de_use_rs2 && bus.de_rs2 != '0 && busy_rs2);
  assign waw_full   = bus.de_wr_reg && bus.de_rd != '0 && full_rd;
  assign stall      = bus.de_valid && (raw_hazard || waw_full || state_q != ST_IDLE);
  assign iss        = bus.de_valid && !stall;
  assign inc_en     = iss && bus.de_wr_reg && bus.de_rd != '0;
  assign dec_en     = bus.wb_valid && bus.wb_wr_reg && bus.wb_rd != '0;

  assign bus.stall_de = stall;
  assign bus.issue    = iss;
  assign bus.flush_fe = (state_q == ST_FLUSH);
  assign bus.busy_br  = (state_q != ST_IDLE);

  // Resolves arriving outside BR_WAIT belong to no tracked branch and are dropped.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iss && bus.de_is_branch) state_d = ST_BR_WAIT;
      end
      ST_BR_WAIT: begin
        if (bus.agex_br_resolve) begin
          if (bus.agex_br_taken) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        // Counter holds the cycles of flush remaining including this one.
        if (flush_cnt_q <= FC_W'(1)) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_agex_hazard_ctrl
// Purpose : Self-checking bench for agex_hazard_ctrl. Directed pipeline
//           scenarios followed by random traffic; a reference model predicts
//           stall_de/issue/flush_fe/busy_br each cycle into a queue and a
//           monitor compares them against the DUT.
// Ports   : none
// Config  : AGEX_HAZARD_WB_BYPASS_EN - model follows the WB bypass rule.
// Revision: 1.0 - initial release
// ============================================================================
module tb_agex_hazard_ctrl;
  import agex_hazard_ctrl_pkg::*;

  localparam int NREG  = 32;
  localparam int CW    = 2;
  localparam int FLUSH = 2;
  localparam int CMAX  = CNT_MAX;

  typedef struct {
    bit rst;
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit wr;
    bit br;
    bit res;
    bit tk;
    bit wbv;
    int wbrd;
    bit wbw;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  agex_hazard_ctrl_if bus_if ();

  agex_hazard_ctrl #(
    .NUM_REGS     (NREG),
    .CNT_W        (CW),
    .FLUSH_CYCLES (FLUSH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding-write counts, branch pending, flush cycles left
  int m_cnt [NREG];
  bit m_wait;
  int m_flush;

  logic [3:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit m_busy(input int r, input stim_t s);
    if (r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef AGEX_HAZARD_WB_BYPASS_EN
    if (m_cnt[r] == 1 && s.wbv && s.wbw && s.wbrd == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic drive(input stim_t s, input bit chk);
    bit hz, waw, blk, st, is;
    @(negedge clk);
    reset                  = s.rst;
    bus_if.de_valid        = s.v;
    bus_if.de_rs1          = 5'(s.rs1);
    bus_if.de_rs2          = 5'(s.rs2);
    bus_if.de_use_rs1      = s.u1;
    bus_if.de_use_rs2      = s.u2;
    bus_if.de_rd           = 5'(s.rd);
    bus_if.de_wr_reg       = s.wr;
    bus_if.de_is_branch    = s.br;
    bus_if.agex_br_resolve = s.res;
    bus_if.agex_br_taken   = s.tk;
    bus_if.wb_valid        = s.wbv;
    bus_if.wb_rd           = 5'(s.wbrd);
    bus_if.wb_wr_reg       = s.wbw;

    hz  = (s.u1 && m_busy(s.rs1, s)) || (s.u2 && m_busy(s.rs2, s));
    waw = s.wr && s.rd != 0 && m_cnt[s.rd] == CMAX;
    blk = m_wait || (m_flush > 0);
    st  = s.v && (hz || waw || blk);
    is  = s.v && !st;
    if (chk) exp_q.push_back({st, is, m_flush > 0, blk});

    if (s.rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_wait  = 0;
      m_flush = 0;
    end else begin
      if (is && s.wr && s.rd != 0) m_cnt[s.rd]++;
      if (s.wbv && s.wbw && s.wbrd != 0 && m_cnt[s.wbrd] > 0 &&
          !(is && s.wr && s.rd == s.wbrd)) m_cnt[s.wbrd]--;
      // Same-register inc/dec: net zero; undo the increment above.
      if (is && s.wr && s.rd != 0 && s.wbv && s.wbw && s.wbrd == s.rd) m_cnt[s.rd]--;
      if (m_flush > 0) begin
        m_flush--;
      end else if (m_wait) begin
        if (s.res) begin
          m_wait = 0;
          if (s.tk) m_flush = FLUSH;
        end
      end else if (is && s.br) begin
        m_wait = 1;
      end
    end
  endtask

  // Monitor: one expected output vector per checked cycle
  initial begin
    logic [3:0] e, g;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus_if.stall_de, bus_if.issue, bus_if.flush_fe, bus_if.busy_br};
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: stall/issue/flush/busy got %b required %b",
                   cyc, g, e);
        end
      end
    end
  end

  initial begin
    stim_t s, rd_inst;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_wait  = 0;
    m_flush = 0;

    s = nop(); s.rst = 1;
    drive(s, 0);
    drive(s, 0);
    drive(nop(), 1);                       // reset state: all outputs 0

    // RAW: ADDI x5 then ADD x6,x5,x1
    s = nop(); s.v = 1; s.rd = 5; s.wr = 1;
    drive(s, 1);
    rd_inst = nop(); rd_inst.v = 1; rd_inst.rs1 = 5; rd_inst.rs2 = 1;
    rd_inst.u1 = 1; rd_inst.u2 = 1; rd_inst.rd = 6; rd_inst.wr = 1;
    repeat (3) drive(rd_inst, 1);
    s = rd_inst; s.wbv = 1; s.wbrd = 5; s.wbw = 1;
    drive(s, 1);
    drive(rd_inst, 1);
    s = nop(); s.wbv = 1; s.wbrd = 6; s.wbw = 1;
    repeat (2) drive(s, 1);

    // Not-taken branch
    s = nop(); s.v = 1; s.br = 1;
    drive(s, 1);
    s = nop(); s.v = 1; s.rs1 = 2; s.u1 = 1;
    repeat (2) drive(s, 1);
    s.res = 1;
    drive(s, 1);
    s.res = 0;
    drive(s, 1);

    // Taken JAL writing x1; stray resolve during flush is ignored
    s = nop(); s.v = 1; s.br = 1; s.rd = 1; s.wr = 1;
    drive(s, 1);
    s = nop(); s.v = 1; s.res = 1; s.tk = 1;
    drive(s, 1);
    drive(s, 1);
    s.res = 0; s.tk = 0;
    repeat (3) drive(s, 1);
    s = nop(); s.wbv = 1; s.wbrd = 1; s.wbw = 1;
    drive(s, 1);

    // Saturation on x7
    s = nop(); s.v = 1; s.rd = 7; s.wr = 1;
    repeat (3) drive(s, 1);
    repeat (2) drive(s, 1);                // waw_full stall
    s.wbv = 1; s.wbrd = 7; s.wbw = 1;
    drive(s, 1);
    s.wbv = 0;
    drive(s, 1);
    s = nop(); s.wbv = 1; s.wbrd = 7; s.wbw = 1;
    repeat (4) drive(s, 1);

    // Simultaneous inc/dec on x3, then a reader of x3; x0 never stalls
    s = nop(); s.v = 1; s.rd = 3; s.wr = 1;
    drive(s, 1);
    s.wbv = 1; s.wbrd = 3; s.wbw = 1;
    drive(s, 1);
    s = nop(); s.v = 1; s.rs1 = 3; s.u1 = 1;
    drive(s, 1);
    s = nop(); s.v = 1; s.rs1 = 0; s.rs2 = 0; s.u1 = 1; s.u2 = 1; s.rd = 0; s.wr = 1;
    repeat (5) drive(s, 1);
    s = nop(); s.wbv = 1; s.wbrd = 3; s.wbw = 1;
    drive(s, 1);

    // Reset in BR_WAIT with cnt[5] = 2
    s = nop(); s.v = 1; s.rd = 5; s.wr = 1;
    repeat (2) drive(s, 1);
    s = nop(); s.v = 1; s.br = 1;
    drive(s, 1);
    s = nop(); s.rst = 1;
    drive(s, 1);
    drive(nop(), 1);
    s = nop(); s.v = 1; s.rs1 = 5; s.u1 = 1;
    drive(s, 1);

    // Random traffic over a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      s = nop();
      s.rst  = ($urandom_range(0, 299) == 0);
      s.v    = ($urandom_range(0, 99) < 75);
      s.rs1  = $urandom_range(0, 7);
      s.rs2  = $urandom_range(0, 7);
      s.u1   = $urandom_range(0, 1);
      s.u2   = $urandom_range(0, 1);
      s.rd   = $urandom_range(0, 7);
      s.wr   = ($urandom_range(0, 99) < 70);
      s.br   = ($urandom_range(0, 99) < 12);
      s.res  = ($urandom_range(0, 99) < 35);
      s.tk   = $urandom_range(0, 1);
      s.wbv  = ($urandom_range(0, 99) < 45);
      s.wbrd = $urandom_range(0, 7);
      s.wbw  = ($urandom_range(0, 99) < 85);
      drive(s, 1);
    end

    repeat (3) drive(nop(), 1);
    @(negedge clk);
    @(negedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/agex_hazard_ctrl.md
Name: agex_hazard_ctrl

Overview:
- Pipeline control unit between DE and AGEX of the 5-stage RV32I core.
- Keeps a per-register scoreboard of in-flight writes and decides each cycle whether the DE instruction issues into AGEX or stalls.
- Sequences control hazards: DE is held while a branch or jump resolves in AGEX, then FE is flushed for a fixed number of cycles on a taken redirect.
- Replaces the unconditional "stall on any branch" behaviour with counted, exact stalls.

Parameters:
- NUM_REGS, 32, architectural register count; index width is log2(NUM_REGS).
- CNT_W, 2, width of each scoreboard counter; at most 2^CNT_W-1 in-flight writes per register.
- FLUSH_CYCLES, 2, number of cycles flush_fe is held after a taken branch or jump.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- de_valid  in  1  DE latch holds a valid instruction.
- de_rs1  in  5  source register 1.
- de_rs2  in  5  source register 2.
- de_use_rs1  in  1  instruction reads rs1.
- de_use_rs2  in  1  instruction reads rs2.
- de_rd  in  5  destination register.
- de_wr_reg  in  1  instruction writes rd.
- de_is_branch  in  1  instruction is BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR.
- agex_br_resolve  in  1  AGEX holds the resolving branch this cycle.
- agex_br_taken  in  1  branch condition true (JAL/JALR always 1).
- wb_valid  in  1  WB retires an instruction this cycle.
- wb_rd  in  5  retiring destination register.
- wb_wr_reg  in  1  retiring instruction writes wb_rd.
- stall_de  out  1  hold the DE latch; AGEX receives a bubble.
- issue  out  1  DE instruction advances to AGEX this cycle.
- flush_fe  out  1  squash FE/DE contents (wrong-path fetch).
- busy_br  out  1  a branch is outstanding (state != IDLE).

Behaviour:
- Reset (sync): all counters 0, state IDLE, flush counter 0. All outputs 0 in the cycle after reset is sampled. Reset asserted mid-branch or mid-flush returns to IDLE immediately and discards everything.
- Outputs are combinational from the registered state/counters and the current inputs. State and counters update at posedge clk.
- raw_hazard = (de_use_rs1 && rs1 != 0 && cnt[rs1] != 0) || (de_use_rs2 && rs2 != 0 && cnt[rs2] != 0).
- waw_full = de_wr_reg && rd != 0 && cnt[rd] == 2^CNT_W-1.
- stall_de = de_valid && (raw_hazard || waw_full || state != IDLE).
- issue = de_valid && !stall_de.
- Scoreboard increment: issue && de_wr_reg && rd != 0.
- Scoreboard decrement: wb_valid && wb_wr_reg && wb_rd != 0.
- Increment and decrement on the same register in the same cycle leave the counter unchanged.
- A decrement of a zero counter is ignored (no wrap).
- Register x0 is never tracked.
- FSM states: IDLE, BR_WAIT, FLUSH.
  - IDLE -> BR_WAIT when issue && de_is_branch.
  - BR_WAIT: stall_de = 1 whenever de_valid.
    - On agex_br_resolve && agex_br_taken: -> FLUSH, load flush counter with FLUSH_CYCLES.
    - On agex_br_resolve && !agex_br_taken: -> IDLE.
    - No resolve: stay in BR_WAIT.
  - FLUSH: flush_fe = 1; counter decrements each cycle; -> IDLE when it reaches 1. FLUSH_CYCLES = 1 gives a one-cycle flush.
  - agex_br_resolve seen in IDLE or FLUSH is ignored.
- Scoreboard updates from WB continue in every state.

Optional Feature:
- Macro: AGEX_HAZARD_WB_BYPASS_EN.
- Defined: a source register does not hazard when cnt == 1 and WB retires that same register this cycle. This relies on the register file's write-before-read, so the instruction issues one cycle earlier.
- Undefined: any nonzero count stalls, regardless of what WB is retiring.

Decomposition:
- Shared package: state encodings (IDLE = 2'd0, BR_WAIT = 2'd1, FLUSH = 2'd2), REG_IDX_W = 5, CNT_MAX constant.
- One sub-module, hazard_scoreboard. It holds the counter array with inc/dec ports and exposes per-port lookups (busy_rs1, busy_rs2, full_rd).
- The FSM and stall logic live in the top level.

Test Plan:
- RAW stall: issue ADDI x5 (wr x5), then ADD x6,x5,x1 next cycle. stall_de = 1 until WB retires x5; issue = 1 in the cycle after the retire (the same cycle with AGEX_HAZARD_WB_BYPASS_EN).
- Not-taken branch: issue BEQ; next instruction stalls. agex_br_resolve = 1, taken = 0 -> IDLE next cycle, flush_fe never asserted, stall released.
- Taken JAL: issue JAL; resolve with taken = 1. flush_fe = 1 for exactly 2 cycles, busy_br = 1 throughout, then IDLE.
- Saturation: three issued writes to x7 with no retire -> cnt = 3. A fourth writer of x7 stalls (waw_full); one retire of x7 releases it.
- Simultaneous inc/dec: issue a write to x3 while WB retires x3 with cnt = 1 -> cnt stays 1. x0 writers and readers never stall.
- Reset mid-op: assert reset in BR_WAIT with cnt[5] = 2 -> the next cycle shows all counters 0, state IDLE, and stall_de/flush_fe/busy_br/issue = 0.
